// File: rtl/seq_chk_pkg.sv
// Shared types and default sizes for the
// toggle/counter stream checker.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int DEF_W          = 10;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/seq_stream_checker_if.sv
// Sample stream bundle: one toggle bit plus
// a W-bit count, qualified by in_valid.
interface seq_stream_checker_if #(
  parameter int W = seq_chk_pkg::DEF_W
) ();

  logic         in_valid;
  logic         in_x;
  logic [W-1:0] in_num;

  modport master (
    output in_valid,
    output in_x,
    output in_num
  );

  modport slave (
    input in_valid,
    input in_x,
    input in_num
  );

endinterface

// File: rtl/seq_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous
// clear and asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = seq_chk_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_stream_checker.sv
// Locks onto a toggle/counter stream and
// counts step mismatches once locked.
module seq_stream_checker #(
  parameter int W          = seq_chk_pkg::DEF_W,
  parameter int LOCK_COUNT = seq_chk_pkg::DEF_LOCK_COUNT,
  parameter int CNT_W      = seq_chk_pkg::DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_stream_checker_if.slave  in_if,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [W-1:0]         last_bad_num
);

  import seq_chk_pkg::*;

  localparam int GW = $clog2(LOCK_COUNT + 1);

  chk_state_e state_q;
  chk_state_e state_d;

  logic [GW-1:0] good_q;
  logic [GW-1:0] good_d;
  logic [GW-1:0] good_inc;
  logic          prev_x_q;
  logic          prev_x_d;
  logic [W-1:0]  prev_num_q;
  logic [W-1:0]  prev_num_d;
  logic [W-1:0]  exp_num;
  logic          match;
  logic          err_pulse_q;
  logic          err_pulse_d;
  logic [W-1:0]  last_bad_q;
  logic [W-1:0]  last_bad_d;
  logic          locked_q;
  logic          locked_d;
  logic          err_en;
  logic          smp_en;

  assign exp_num  = prev_num_q + W'(1);
  assign match    = (in_if.in_num == exp_num) &&
                    (in_if.in_x != prev_x_q);
  assign good_inc = good_q + GW'(1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: capture, lock, drop on mismatch
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (in_if.in_valid) begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (match && (good_inc == GW'(LOCK_COUNT))) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // datapath updates and counter enables
  always_comb begin
    good_d      = good_q;
    prev_x_d    = prev_x_q;
    prev_num_d  = prev_num_q;
    err_pulse_d = 1'b0;
    last_bad_d  = last_bad_q;
    err_en      = 1'b0;
    smp_en      = 1'b0;
    if (clear) begin
      good_d     = '0;
      prev_x_d   = 1'b0;
      prev_num_d = '0;
    end else if (in_if.in_valid) begin
      prev_x_d   = in_if.in_x;
      prev_num_d = in_if.in_num;
      unique case (state_q)
        IDLE: good_d = '0;
        SYNC: good_d = match ? good_inc : '0;
        LOCKED: begin
          smp_en = 1'b1;
          if (!match) begin
            err_en      = 1'b1;
            err_pulse_d = 1'b1;
            last_bad_d  = in_if.in_num;
            good_d      = '0;
          end
        end
        default: good_d = '0;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q      <= '0;
      prev_x_q    <= 1'b0;
      prev_num_q  <= '0;
      err_pulse_q <= 1'b0;
      last_bad_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      good_q      <= good_d;
      prev_x_q    <= prev_x_d;
      prev_num_q  <= prev_num_d;
      err_pulse_q <= err_pulse_d;
      last_bad_q  <= last_bad_d;
      locked_q    <= locked_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (err_en),
    .cnt   (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_smp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (smp_en),
    .cnt   (sample_cnt)
  );

  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign last_bad_num = last_bad_q;

endmodule

// File: doc/seq_stream_checker.md
# seq_stream_checker

Receive-side checker for the toggle/counter stimulus stream our benches generate: one toggling bit plus a W-bit incrementing count per sample. It locks onto the stream, then checks every valid sample for a +1 (mod 2^W) count step and an inverted toggle bit, and counts and reports mismatches. It sits at the consumer end of any path carrying that stream, in place of waveform inspection of the dump.

## Interface
Parameters:
- W, 10, width of the count field
- LOCK_COUNT, 4, consecutive good steps required to declare lock (≥1)
- CNT_W, 16, width of the error and sample counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present this cycle
- in_x  in  1  toggle bit of the sample
- in_num  in  W  count field of the sample
- clear  in  1  synchronous clear of counters and state to IDLE
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED
- err_cnt  out  CNT_W  saturating mismatch count
- sample_cnt  out  CNT_W  saturating count of samples checked in LOCKED
- last_bad_num  out  W  in_num of the most recent mismatching sample

## Operation
- Reset (rst_n low, async): state IDLE; locked=0, err_pulse=0, err_cnt=0, sample_cnt=0, last_bad_num=0, good run counter=0, stored prev_x=0, prev_num=0.
- Samples accepted only when in_valid=1; in_valid=0 cycles leave all state unchanged (no gap penalty).
- Expected sample: exp_num = prev_num + 1 truncated to W bits (2^W−1 → 0 is a good step); exp_x = ~prev_x. Match iff in_num==exp_num and in_x==exp_x.
- Every accepted sample stores (in_x, in_num) as the new prev, whether good or bad.
- States:
  - IDLE: first valid sample → store, good=0, go SYNC. Nothing checked.
  - SYNC: match → good+1; when good reaches LOCK_COUNT go LOCKED. Mismatch → good=0, stay SYNC, no error reported.
  - LOCKED: match → sample_cnt+1. Mismatch → sample_cnt+1, err_cnt+1, err_pulse=1, last_bad_num=in_num, go SYNC with good=0.
- Counters saturate at 2^CNT_W−1; no wrap.
- clear=1 (synchronous): same values as reset, except last_bad_num holds. clear has priority over a same-cycle sample (sample discarded).

## Timing
- All outputs registered. Sample at edge N → locked/err_pulse/counters reflect it after edge N (visible in cycle N+1).
- Lock latency from IDLE with a clean stream: LOCK_COUNT+1 valid samples; locked rises after the edge that accepts sample LOCK_COUNT+1.
- err_pulse high exactly one cycle per LOCKED mismatch; back-to-back mismatches produce only one pulse (the second is in SYNC).
- locked falls after the same edge as err_pulse rises.
- Async reset mid-stream: outputs go to reset values immediately; first post-reset sample treated as IDLE capture.

## Structure
- Shared package seq_chk_pkg: state enum (IDLE, SYNC, LOCKED), default W/LOCK_COUNT/CNT_W constants.
- One natural sub-module: sat_counter (CNT_W-wide, enable, sync clear, async reset), instanced twice for err_cnt and sample_cnt.
- Good-run counter width $clog2(LOCK_COUNT+1).

## Test plan
- Clean stream x=0,1,0,… num=0,1,2,… valid every cycle, LOCK_COUNT=4 → locked after 5th sample; 500 samples → err_cnt=0, sample_cnt=495.
- Wrap: W=10, stream through num=1022,1023,0,1 while locked → no err_pulse, locked stays 1.
- Skip: locked, then num jumps 40→42 → one err_pulse, err_cnt=1, last_bad_num=42, locked=0; relocks 4 samples later.
- Toggle fault: locked, num correct but x repeated → err_cnt=1; following fault in SYNC → err_cnt stays 1.
- Gaps: in_valid low on alternate cycles, clean stream → lock after 5 valid samples, no errors.
- Reset/clear: rst_n low mid-stream → all outputs 0 immediately; clear with err_cnt=3 → err_cnt=0, state IDLE, last_bad_num held; CNT_W=2 with 5 mismatches → err_cnt=3.
